// File: rtl/fi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fi_pkg
// Purpose : Shared types and constants for the fault-injection campaign
//           controller (sequencer states, fault-target function codes,
//           run classification codes, sweep limits and helper functions).
// Revision: 1.0 - initial release
// ============================================================================
package fi_pkg;

  // Campaign sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GOLD_LD   = 3'd1,
    ST_GOLD_WAIT = 3'd2,
    ST_INJ_LD    = 3'd3,
    ST_INJ_WAIT  = 3'd4,
    ST_CLASSIFY  = 3'd5,
    ST_ADVANCE   = 3'd6,
    ST_FIN       = 3'd7
  } fi_state_e;

  // Targeted AES function codes driven on func_FI.
  localparam logic [1:0] FI_SBOX = 2'd0;
  localparam logic [1:0] FI_SHRW = 2'd1;
  localparam logic [1:0] FI_MXCL = 2'd2;
  localparam logic [1:0] FI_KYXR = 2'd3;

  // Outcome of one faulty run.
  typedef enum logic [1:0] {
    RES_TIMEOUT    = 2'd0,
    RES_DETECTED   = 2'd1,
    RES_UNDETECTED = 2'd2,
    RES_MASKED     = 2'd3
  } fi_result_e;

  // Last index of each inner sweep dimension.
  localparam logic [1:0] ROW_MAX = 2'd3;
  localparam logic [1:0] COL_MAX = 2'd3;
  localparam logic [3:0] BIT_MAX = 4'd7;

  // Lowest function selected by the mask (caller guarantees mask != 0).
  function automatic logic [1:0] fi_first_func(input logic [3:0] mask);
    logic [1:0] r;
    r = FI_SBOX;
    for (int f = 3; f >= 0; f--) begin
      if (mask[f]) r = 2'(f);
    end
    return r;
  endfunction

  // Next selected function strictly above cur: {found, index}.
  function automatic logic [2:0] fi_next_func(input logic [3:0] mask, input logic [1:0] cur);
    logic [2:0] r;
    r = 3'b000;
    for (int f = 3; f >= 0; f--) begin
      if (mask[f] && (f > int'(cur))) r = {1'b1, 2'(f)};
    end
    return r;
  endfunction

  // Priority classification of a faulty run; first match wins.
  function automatic fi_result_e fi_classify(input logic timeout, input logic fault,
                                             input logic differs);
    fi_result_e r;
    if (timeout)      r = RES_TIMEOUT;
    else if (fault)   r = RES_DETECTED;
    else if (differs) r = RES_UNDETECTED;
    else              r = RES_MASKED;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fi_sweep_cnt.sv
`default_nettype none
// ============================================================================
// Module  : fi_sweep_cnt
// Purpose : Odometer over the injection points. Innermost first: bit
//           (skipped in byte mode), column, row, round, then the selected
//           functions in ascending order. load_i jumps to the first point,
//           step_i advances one point, last_o flags the final point.
// Revision: 1.0 - initial release
// ============================================================================
module fi_sweep_cnt
  import fi_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       step_i,
  input  logic       byte_mode_i,
  input  logic [3:0] func_mask_i,
  output logic [1:0] func_o,
  output logic [3:0] round_o,
  output logic [1:0] row_o,
  output logic [1:0] col_o,
  output logic [3:0] bit_o,
  output logic       last_o
);

  localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS - 1);

  logic [1:0] func_q, func_d;
  logic [3:0] round_q, round_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic [3:0] bit_q, bit_d;
  logic [2:0] w_next;
  logic       w_bit_wrap;

  // Next point: load resets to the first point, step carries innermost-first.
  always_comb begin
    func_d     = func_q;
    round_d    = round_q;
    row_d      = row_q;
    col_d      = col_q;
    bit_d      = bit_q;
    w_next     = fi_next_func(func_mask_i, func_q);
    w_bit_wrap = byte_mode_i || (bit_q == BIT_MAX);
    if (load_i) begin
      func_d  = fi_first_func(func_mask_i);
      round_d = '0;
      row_d   = '0;
      col_d   = '0;
      bit_d   = '0;
    end else if (step_i) begin
      if (!w_bit_wrap) begin
        bit_d = bit_q + 4'd1;
      end else begin
        bit_d = '0;
        if (col_q != COL_MAX) begin
          col_d = col_q + 2'd1;
        end else begin
          col_d = '0;
          if (row_q != ROW_MAX) begin
            row_d = row_q + 2'd1;
          end else begin
            row_d = '0;
            if (round_q != ROUND_LAST) begin
              round_d = round_q + 4'd1;
            end else begin
              round_d = '0;
              func_d  = w_next[1:0];
            end
          end
        end
      end
    end
  end

  // Point registers; they hold their value when neither load nor step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      func_q  <= '0;
      round_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      bit_q   <= '0;
    end else begin
      func_q  <= func_d;
      round_q <= round_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bit_q   <= bit_d;
    end
  end

  assign func_o  = func_q;
  assign round_o = round_q;
  assign row_o   = row_q;
  assign col_o   = col_q;
  assign bit_o   = bit_q;
  assign last_o  = w_bit_wrap && (col_q == COL_MAX) && (row_q == ROW_MAX) &&
                   (round_q == ROUND_LAST) && !w_next[2];

endmodule
`default_nettype wire

// File: rtl/fi_campaign_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fi_campaign_ctrl
// Purpose : Automated fault-injection campaign sequencer for aes_top. Runs a
//           fault-free golden encryption, then sweeps all selected injection
//           points and classifies each faulty run as detected, undetected,
//           masked or timeout in saturating counters.
// Options : FI_STOP_ON_UNDETECTED_EN - stop at the first undetected run and
//           expose the 'stopped' output.
// Revision: 1.0 - initial release
// ============================================================================
module fi_campaign_ctrl
  import fi_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int MAX_WAIT   = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     cfg_text,
  input  logic [127:0]     cfg_key,
  input  logic             cfg_byte_mode,
  input  logic [3:0]       cfg_func_mask,
  output logic             aes_ld,
  output logic [127:0]     aes_key,
  output logic [127:0]     aes_text_in,
  input  logic             aes_done,
  input  logic [127:0]     aes_text_out,
  input  logic             aes_fault_detected,
  output logic             en_FI,
  output logic             mode_FI,
  output logic [3:0]       func_FI,
  output logic [3:0]       round_FI,
  output logic [1:0]       row_FI,
  output logic [1:0]       column_FI,
  output logic [3:0]       bit_index_FI,
  output logic             busy,
  output logic             done,
  output logic [127:0]     golden_out,
  output logic             golden_err,
  output logic [CNT_W-1:0] cnt_detected,
  output logic [CNT_W-1:0] cnt_undetected,
  output logic [CNT_W-1:0] cnt_masked,
  output logic [CNT_W-1:0] cnt_timeout
`ifdef FI_STOP_ON_UNDETECTED_EN
  ,
  output logic             stopped
`endif
);

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};

  fi_state_e          state_q, state_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       text_q, text_d;
  logic               bmode_q, bmode_d;
  logic [3:0]         mask_q, mask_d;
  logic [127:0]       golden_q, golden_d;
  logic               gerr_q, gerr_d;
  logic [CNT_W-1:0]   det_q, det_d, und_q, und_d, msk_q, msk_d, tmo_q, tmo_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               arm_q, arm_d;
  logic               sticky_q, sticky_d;
  logic               timeout_q, timeout_d;
  logic [127:0]       cap_q, cap_d;
  logic               first_q, first_d;
  logic               stop_q, stop_d;
  fi_result_e         w_res;
  logic               w_load, w_step, w_last;
  logic [1:0]         w_func;

  // Sequencer next-state, datapath updates and sweep control.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    text_d    = text_q;
    bmode_d   = bmode_q;
    mask_d    = mask_q;
    golden_d  = golden_q;
    gerr_d    = gerr_q;
    det_d     = det_q;
    und_d     = und_q;
    msk_d     = msk_q;
    tmo_d     = tmo_q;
    wait_d    = wait_q;
    arm_d     = arm_q;
    sticky_d  = sticky_q;
    timeout_d = timeout_q;
    cap_d     = cap_q;
    first_d   = first_q;
    stop_d    = stop_q;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_res     = fi_classify(timeout_q, sticky_q, cap_q != golden_q);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d    = cfg_key;
          text_d   = cfg_text;
          bmode_d  = cfg_byte_mode;
          mask_d   = cfg_func_mask;
          golden_d = '0;
          gerr_d   = 1'b0;
          det_d    = '0;
          und_d    = '0;
          msk_d    = '0;
          tmo_d    = '0;
          stop_d   = 1'b0;
          state_d  = ST_GOLD_LD;
        end
      end
      ST_GOLD_LD, ST_INJ_LD: begin
        // A done still high from the previous run is ignored until aes_done
        // has been seen low; the ld cycle itself may provide that sample.
        wait_d    = '0;
        arm_d     = ~aes_done;
        sticky_d  = 1'b0;
        timeout_d = 1'b0;
        state_d   = (state_q == ST_GOLD_LD) ? ST_GOLD_WAIT : ST_INJ_WAIT;
      end
      ST_GOLD_WAIT, ST_INJ_WAIT: begin
        sticky_d = sticky_q | aes_fault_detected;
        wait_d   = wait_q + WAIT_W'(1);
        arm_d    = arm_q | ~aes_done;
        if (arm_q && aes_done) begin
          cap_d = aes_text_out;
          if (state_q == ST_INJ_WAIT) begin
            state_d = ST_CLASSIFY;
          end else if (sticky_d) begin
            gerr_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            golden_d = aes_text_out;
            first_d  = 1'b1;
            state_d  = ST_ADVANCE;
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          if (state_q == ST_INJ_WAIT) begin
            state_d = ST_CLASSIFY;
          end else begin
            gerr_d  = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_CLASSIFY: begin
        state_d = ST_ADVANCE;
        case (w_res)
          RES_TIMEOUT:    if (tmo_q != CNT_SAT) tmo_d = tmo_q + CNT_W'(1);
          RES_DETECTED:   if (det_q != CNT_SAT) det_d = det_q + CNT_W'(1);
          RES_UNDETECTED: begin
            if (und_q != CNT_SAT) und_d = und_q + CNT_W'(1);
`ifdef FI_STOP_ON_UNDETECTED_EN
            stop_d  = 1'b1;
            state_d = ST_FIN;
`endif
          end
          default:        if (msk_q != CNT_SAT) msk_d = msk_q + CNT_W'(1);
        endcase
      end
      ST_ADVANCE: begin
        if (first_q) begin
          first_d = 1'b0;
          if (mask_q == 4'b0000) begin
            state_d = ST_FIN;
          end else begin
            w_load  = 1'b1;
            state_d = ST_INJ_LD;
          end
        end else if (w_last) begin
          state_d = ST_FIN;
        end else begin
          w_step  = 1'b1;
          state_d = ST_INJ_LD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and campaign registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      text_q    <= '0;
      bmode_q   <= 1'b0;
      mask_q    <= '0;
      golden_q  <= '0;
      gerr_q    <= 1'b0;
      det_q     <= '0;
      und_q     <= '0;
      msk_q     <= '0;
      tmo_q     <= '0;
      wait_q    <= '0;
      arm_q     <= 1'b0;
      sticky_q  <= 1'b0;
      timeout_q <= 1'b0;
      cap_q     <= '0;
      first_q   <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      text_q    <= text_d;
      bmode_q   <= bmode_d;
      mask_q    <= mask_d;
      golden_q  <= golden_d;
      gerr_q    <= gerr_d;
      det_q     <= det_d;
      und_q     <= und_d;
      msk_q     <= msk_d;
      tmo_q     <= tmo_d;
      wait_q    <= wait_d;
      arm_q     <= arm_d;
      sticky_q  <= sticky_d;
      timeout_q <= timeout_d;
      cap_q     <= cap_d;
      first_q   <= first_d;
      stop_q    <= stop_d;
    end
  end

  fi_sweep_cnt #(
    .NUM_ROUNDS (NUM_ROUNDS)
  ) u_sweep (
    .clk         (clk),
    .rst         (rst),
    .load_i      (w_load),
    .step_i      (w_step),
    .byte_mode_i (bmode_q),
    .func_mask_i (mask_q),
    .func_o      (w_func),
    .round_o     (round_FI),
    .row_o       (row_FI),
    .col_o       (column_FI),
    .bit_o       (bit_index_FI),
    .last_o      (w_last)
  );

  assign aes_ld         = (state_q == ST_GOLD_LD) || (state_q == ST_INJ_LD);
  assign en_FI          = (state_q == ST_INJ_LD) || (state_q == ST_INJ_WAIT);
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done           = (state_q == ST_FIN);
  assign mode_FI        = busy & bmode_q;
  assign func_FI        = {2'b00, w_func};
  assign aes_key        = key_q;
  assign aes_text_in    = text_q;
  assign golden_out     = golden_q;
  assign golden_err     = gerr_q;
  assign cnt_detected   = det_q;
  assign cnt_undetected = und_q;
  assign cnt_masked     = msk_q;
  assign cnt_timeout    = tmo_q;
`ifdef FI_STOP_ON_UNDETECTED_EN
  assign stopped        = stop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fi_campaign_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fi_campaign_ctrl
// Purpose : Directed self-checking bench for fi_campaign_ctrl with a
//           behavioural aes_top stand-in whose response style is selectable.
// Options : FI_STOP_ON_UNDETECTED_EN - exercises the stop-on-undetected port.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fi_campaign_ctrl;

  localparam int NR = 10;
  localparam int MW = 64;
  localparam int CW = 16;
  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] TXT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] GOLD = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // aes stand-in behaviours
  localparam int SM_NORMAL = 0;  // golden text, no fault
  localparam int SM_DETECT = 1;  // every injected run raises fault_detected
  localparam int SM_HANG   = 2;  // never raises done on injected runs
  localparam int SM_SILENT = 3;  // never raises done on the golden run
  localparam int SM_CORRUPT = 4; // silently corrupts injected runs at round 3
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [127:0] cfg_text = '0, cfg_key = '0;
  logic cfg_byte_mode = 1'b0;
  logic [3:0] cfg_func_mask = '0;
  logic aes_ld, en_FI, mode_FI, busy, done, golden_err;
  logic [127:0] aes_key, aes_text_in, golden_out;
  logic [3:0] func_FI, round_FI, bit_index_FI;
  logic [1:0] row_FI, column_FI;
  logic [CW-1:0] cnt_detected, cnt_undetected, cnt_masked, cnt_timeout;
  logic aes_done = 1'b0;
  logic aes_fault_detected = 1'b0;
  logic [127:0] aes_text_out = '0;
`ifdef FI_STOP_ON_UNDETECTED_EN
  logic stopped;
`endif

  int n_vec = 0;
  int n_err = 0;
  int stub_mode = SM_NORMAL;

  fi_campaign_ctrl #(.NUM_ROUNDS(NR), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_text(cfg_text), .cfg_key(cfg_key),
    .cfg_byte_mode(cfg_byte_mode), .cfg_func_mask(cfg_func_mask),
    .aes_ld(aes_ld), .aes_key(aes_key), .aes_text_in(aes_text_in),
    .aes_done(aes_done), .aes_text_out(aes_text_out),
    .aes_fault_detected(aes_fault_detected),
    .en_FI(en_FI), .mode_FI(mode_FI), .func_FI(func_FI), .round_FI(round_FI),
    .row_FI(row_FI), .column_FI(column_FI), .bit_index_FI(bit_index_FI),
    .busy(busy), .done(done), .golden_out(golden_out), .golden_err(golden_err),
    .cnt_detected(cnt_detected), .cnt_undetected(cnt_undetected),
    .cnt_masked(cnt_masked), .cnt_timeout(cnt_timeout)
`ifdef FI_STOP_ON_UNDETECTED_EN
    , .stopped(stopped)
`endif
  );

  always #5 clk = ~clk;

  // aes_top stand-in: done drops on ld, rises LAT+1 cycles later and stays high.
  int   st_cnt = 0;
  logic st_busy = 1'b0, st_inj = 1'b0;
  logic [3:0] st_round = '0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      aes_done <= 1'b0; aes_fault_detected <= 1'b0; aes_text_out <= '0;
      st_busy <= 1'b0; st_cnt <= 0; st_inj <= 1'b0; st_round <= '0;
    end else begin
      aes_fault_detected <= 1'b0;
      if (aes_ld) begin
        aes_done <= 1'b0; st_busy <= 1'b1; st_cnt <= 0;
        st_inj <= en_FI; st_round <= round_FI;
      end else if (st_busy) begin
        if (st_cnt == LAT) begin
          st_busy <= 1'b0;
          if (!((stub_mode == SM_SILENT && !st_inj) || (stub_mode == SM_HANG && st_inj))) begin
            aes_done <= 1'b1;
            aes_fault_detected <= (stub_mode == SM_DETECT) && st_inj;
            aes_text_out <= (stub_mode == SM_CORRUPT && st_inj && st_round == 4'd3) ?
                            (GOLD ^ 128'h1) : GOLD;
          end
        end else begin
          st_cnt <= st_cnt + 1;
        end
      end
    end
  end

  // Passive observers, sampled on the falling edge.
  int   ld_cnt = 0, key_bad = 0, en_len = 0, en_pulses = 0, en_bad = 0, mode_bad = 0;
  int   exp_en_len = 0;
  logic exp_mode = 1'b0;
  logic ld_en_last = 1'b0;
  always @(negedge clk) begin
    if (aes_ld) begin
      ld_cnt++;
      ld_en_last = en_FI;
      if (aes_key !== KEY || aes_text_in !== TXT) key_bad++;
    end
    if (en_FI === 1'b1) en_len++;
    else if (en_len != 0) begin
      en_pulses++;
      if (exp_en_len != 0 && en_len != exp_en_len) en_bad++;
      en_len = 0;
    end
    if (busy === 1'b1 && mode_FI !== exp_mode) mode_bad++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Start one campaign and wait (bounded) for the done pulse. With poke set,
  // start is pulsed again mid-campaign; cfg inputs are scrambled after start.
  task automatic run_campaign(input logic bmode, input logic [3:0] mask, input int limit,
                              input bit poke, output int cycles, output bit seen);
    seen = 1'b0; cycles = 0;
    @(negedge clk);
    cfg_key = KEY; cfg_text = TXT; cfg_byte_mode = bmode; cfg_func_mask = mask;
    exp_mode = bmode; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_key = ~KEY; cfg_text = ~TXT; cfg_byte_mode = ~bmode; cfg_func_mask = ~mask;
    while (!seen && cycles < limit) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        cycles++;
        start = (poke && cycles == 100);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({aes_ld, en_FI, mode_FI, busy, done, golden_err} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 000000", {aes_ld, en_FI, mode_FI, busy, done, golden_err});
    end
    n_vec++;
    if ({func_FI, round_FI, row_FI, column_FI, bit_index_FI} !== 16'h0) begin
      n_err++; $display("FAIL reset_fi: got %h expected 0000", {func_FI, round_FI, row_FI, column_FI, bit_index_FI});
    end
    n_vec++;
    if ({cnt_detected, cnt_undetected, cnt_masked, cnt_timeout} !== 64'h0) begin
      n_err++; $display("FAIL reset_cnt: got %h expected 0", {cnt_detected, cnt_undetected, cnt_masked, cnt_timeout});
    end
    n_vec++;
    if ({aes_key, aes_text_in, golden_out} !== 384'h0) begin
      n_err++; $display("FAIL reset_data: got nonzero key/text/golden, expected 0");
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || aes_ld !== 1'b0) begin
      n_err++; $display("FAIL idle_no_start: got busy=%b ld=%b expected 0 0", busy, aes_ld);
    end
  endtask

  task automatic test_golden_only;
    int cyc; bit seen; int ld0, kb0;
    stub_mode = SM_NORMAL; ld0 = ld_cnt; kb0 = key_bad;
    run_campaign(1'b0, 4'b0000, 300, 1'b0, cyc, seen);
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL golden_done: got no done in %0d cycles expected done", cyc); end
    n_vec++;
    if (golden_out !== GOLD) begin n_err++; $display("FAIL golden_out: got %h expected %h", golden_out, GOLD); end
    n_vec++;
    if (ld_cnt - ld0 != 1 || ld_en_last !== 1'b0) begin
      n_err++; $display("FAIL golden_ld: got %0d ld (en=%b) expected 1 (en=0)", ld_cnt - ld0, ld_en_last);
    end
    n_vec++;
    if ({cnt_detected, cnt_undetected, cnt_masked, cnt_timeout, golden_err, busy} !== 66'h0) begin
      n_err++; $display("FAIL golden_cnt: got cnts %h err=%b busy=%b expected all 0",
                        {cnt_detected, cnt_undetected, cnt_masked, cnt_timeout}, golden_err, busy);
    end
    n_vec++;
    if (key_bad != kb0) begin n_err++; $display("FAIL key_latch: got %0d bad ld cycles expected 0", key_bad - kb0); end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse: got done=%b one cycle later expected 0", done); end
  endtask

  task automatic test_detect_byte;
    int cyc; bit seen; int ld0, mb0;
    stub_mode = SM_DETECT; ld0 = ld_cnt; mb0 = mode_bad;
    run_campaign(1'b1, 4'b0001, 5000, 1'b1, cyc, seen);
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL detect_done: got no done in %0d cycles expected done", cyc); end
    n_vec++;
    if ({cnt_detected, cnt_undetected, cnt_masked, cnt_timeout} !== {16'd160, 16'd0, 16'd0, 16'd0}) begin
      n_err++; $display("FAIL detect_cnt: got det=%0d und=%0d msk=%0d tmo=%0d expected 160 0 0 0",
                        cnt_detected, cnt_undetected, cnt_masked, cnt_timeout);
    end
    n_vec++;
    if (ld_cnt - ld0 != 161) begin n_err++; $display("FAIL detect_ld: got %0d expected 161", ld_cnt - ld0); end
    n_vec++;
    if ({func_FI, round_FI, row_FI, column_FI, bit_index_FI} !== {4'd0, 4'd9, 2'd3, 2'd3, 4'd0}) begin
      n_err++; $display("FAIL detect_last: got %h expected %h", {func_FI, round_FI, row_FI, column_FI, bit_index_FI},
                        {4'd0, 4'd9, 2'd3, 2'd3, 4'd0});
    end
    n_vec++;
    if (mode_bad != mb0) begin n_err++; $display("FAIL mode_fi_byte: got %0d bad cycles expected 0", mode_bad - mb0); end
  endtask

  task automatic test_masked_bit;
    int cyc; bit seen; int ld0, mb0;
    stub_mode = SM_NORMAL; ld0 = ld_cnt; mb0 = mode_bad;
    run_campaign(1'b0, 4'b1000, 15000, 1'b0, cyc, seen);
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL masked_done: got no done in %0d cycles expected done", cyc); end
    n_vec++;
    if ({cnt_detected, cnt_undetected, cnt_masked, cnt_timeout} !== {16'd0, 16'd0, 16'd1280, 16'd0}) begin
      n_err++; $display("FAIL masked_cnt: got det=%0d und=%0d msk=%0d tmo=%0d expected 0 0 1280 0",
                        cnt_detected, cnt_undetected, cnt_masked, cnt_timeout);
    end
    n_vec++;
    if ({func_FI, round_FI, row_FI, column_FI, bit_index_FI} !== {4'd3, 4'd9, 2'd3, 2'd3, 4'd7}) begin
      n_err++; $display("FAIL masked_last: got %h expected %h", {func_FI, round_FI, row_FI, column_FI, bit_index_FI},
                        {4'd3, 4'd9, 2'd3, 2'd3, 4'd7});
    end
    n_vec++;
    if (ld_cnt - ld0 != 1281 || mode_bad != mb0) begin
      n_err++; $display("FAIL masked_ld: got %0d ld, %0d bad mode expected 1281, 0", ld_cnt - ld0, mode_bad - mb0);
    end
  endtask

  task automatic test_timeout;
    int cyc; bit seen; int ep0, eb0;
    stub_mode = SM_HANG; ep0 = en_pulses; eb0 = en_bad;
    exp_en_len = MW + 1;  // INJ_LD cycle plus MAX_WAIT wait cycles
    run_campaign(1'b1, 4'b0001, 15000, 1'b0, cyc, seen);
    @(negedge clk);
    exp_en_len = 0;
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL timeout_done: got no done in %0d cycles expected done", cyc); end
    n_vec++;
    if ({cnt_detected, cnt_undetected, cnt_masked, cnt_timeout} !== {16'd0, 16'd0, 16'd0, 16'd160}) begin
      n_err++; $display("FAIL timeout_cnt: got det=%0d und=%0d msk=%0d tmo=%0d expected 0 0 0 160",
                        cnt_detected, cnt_undetected, cnt_masked, cnt_timeout);
    end
    n_vec++;
    if (en_pulses - ep0 != 160 || en_bad != eb0) begin
      n_err++; $display("FAIL timeout_len: got %0d runs, %0d wrong length expected 160, 0",
                        en_pulses - ep0, en_bad - eb0);
    end
  endtask

  task automatic test_golden_silent;
    int cyc; bit seen; int ld0;
    stub_mode = SM_SILENT; ld0 = ld_cnt;
    run_campaign(1'b1, 4'b0001, 500, 1'b0, cyc, seen);
    n_vec++;
    if (!seen || golden_err !== 1'b1) begin
      n_err++; $display("FAIL golden_err: got seen=%b err=%b expected 1 1", seen, golden_err);
    end
    n_vec++;
    if (ld_cnt - ld0 != 1 || {cnt_detected, cnt_undetected, cnt_masked, cnt_timeout} !== 64'h0) begin
      n_err++; $display("FAIL golden_err_runs: got %0d ld cnts=%h expected 1 ld, 0", ld_cnt - ld0,
                        {cnt_detected, cnt_undetected, cnt_masked, cnt_timeout});
    end
  endtask

  task automatic test_reset_mid;
    int cyc; bit seen; int inj, ld0, guard;
    stub_mode = SM_NORMAL; inj = 0; guard = 0;
    @(negedge clk);
    cfg_key = KEY; cfg_text = TXT; cfg_byte_mode = 1'b1; cfg_func_mask = 4'b0001;
    exp_mode = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (inj < 3 && guard < 500) begin
      if (aes_ld === 1'b1 && en_FI === 1'b1) inj++;
      if (inj < 3) begin @(negedge clk); guard++; end
    end
    @(negedge clk);
    n_vec++;
    if (en_FI !== 1'b1 || column_FI !== 2'd2) begin
      n_err++; $display("FAIL mid_point: got en=%b col=%0d expected 1 2", en_FI, column_FI);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({aes_ld, en_FI, mode_FI, busy, done, func_FI, round_FI, row_FI, column_FI, bit_index_FI} !== 21'h0) begin
      n_err++; $display("FAIL async_rst_ctrl: got %h expected 0",
                        {aes_ld, en_FI, mode_FI, busy, done, func_FI, round_FI, row_FI, column_FI, bit_index_FI});
    end
    n_vec++;
    if ({golden_out, aes_key, cnt_masked} !== 272'h0) begin
      n_err++; $display("FAIL async_rst_data: got golden=%h msk=%0d expected 0", golden_out, cnt_masked);
    end
    @(negedge clk); rst = 1'b1;
    ld0 = ld_cnt;
    run_campaign(1'b0, 4'b0000, 300, 1'b0, cyc, seen);
    n_vec++;
    if (!seen || golden_out !== GOLD || ld_cnt - ld0 != 1 || ld_en_last !== 1'b0) begin
      n_err++; $display("FAIL replay_golden: got seen=%b golden=%h ld=%0d en=%b expected 1 %h 1 0",
                        seen, golden_out, ld_cnt - ld0, ld_en_last, GOLD);
    end
  endtask

  task automatic test_undetected;
    int cyc; bit seen;
    stub_mode = SM_CORRUPT;
    run_campaign(1'b1, 4'b0001, 5000, 1'b0, cyc, seen);
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL undet_done: got no done in %0d cycles expected done", cyc); end
`ifdef FI_STOP_ON_UNDETECTED_EN
    n_vec++;
    if (stopped !== 1'b1 || {round_FI, row_FI, column_FI} !== {4'd3, 2'd0, 2'd0}) begin
      n_err++; $display("FAIL stop_point: got stopped=%b round=%0d row=%0d col=%0d expected 1 3 0 0",
                        stopped, round_FI, row_FI, column_FI);
    end
    n_vec++;
    if ({cnt_undetected, cnt_masked, cnt_detected, cnt_timeout} !== {16'd1, 16'd48, 16'd0, 16'd0}) begin
      n_err++; $display("FAIL stop_cnt: got und=%0d msk=%0d det=%0d tmo=%0d expected 1 48 0 0",
                        cnt_undetected, cnt_masked, cnt_detected, cnt_timeout);
    end
    stub_mode = SM_NORMAL;
    run_campaign(1'b0, 4'b0000, 300, 1'b0, cyc, seen);
    n_vec++;
    if (!seen || stopped !== 1'b0) begin
      n_err++; $display("FAIL stop_clear: got seen=%b stopped=%b expected 1 0", seen, stopped);
    end
`else
    n_vec++;
    if ({cnt_undetected, cnt_masked, cnt_detected, cnt_timeout} !== {16'd16, 16'd144, 16'd0, 16'd0}) begin
      n_err++; $display("FAIL undet_cnt: got und=%0d msk=%0d det=%0d tmo=%0d expected 16 144 0 0",
                        cnt_undetected, cnt_masked, cnt_detected, cnt_timeout);
    end
    n_vec++;
    if (round_FI !== 4'd9) begin n_err++; $display("FAIL undet_sweep: got round=%0d expected 9", round_FI); end
`endif
  endtask

  initial begin
    test_reset();
    test_golden_only();
    test_detect_byte();
    test_masked_bit();
    test_timeout();
    test_golden_silent();
    test_reset_mid();
    test_undetected();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fi_campaign_ctrl.md
Name: fi_campaign_ctrl

Overview:
- Sequencer that runs automated fault-injection campaigns on aes_top. It drives the CED/FI configuration inputs and the ld/key/text_in load sequence.
- It performs one fault-free golden encryption, then sweeps the selected injection points. Each faulty run is classified as detected, undetected (silent corruption), masked or timeout, using aes_top's done, text_out and fault_detected.
- Sits between a host/bench and aes_top, replacing manual file-driven single-shot injection.

Parameters:
- NUM_ROUNDS, 10, number of round_FI values swept (0..NUM_ROUNDS-1).
- MAX_WAIT, 64, cycles allowed from ld to done before a run is a timeout.
- CNT_W, 16, width of each result counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- start  input  1  single-cycle pulse; begins a campaign when idle.
- cfg_text  input  128  plaintext used for every run.
- cfg_key  input  128  key used for every run.
- cfg_byte_mode  input  1  0 = bit faults, 1 = byte faults.
- cfg_func_mask  input  4  bit f set = sweep func f (0 sbox, 1 shiftrow, 2 mixcolumn, 3 keyxor).
- aes_ld  output  1  load strobe to aes_top.
- aes_key  output  128  key to aes_top.
- aes_text_in  output  128  plaintext to aes_top.
- aes_done  input  1  aes_top done.
- aes_text_out  input  128  aes_top ciphertext.
- aes_fault_detected  input  1  aes_top CED flag.
- en_FI  output  1  injector enable.
- mode_FI  output  1  injector mode.
- func_FI  output  4  targeted function.
- round_FI  output  4  targeted round.
- row_FI  output  2  targeted row.
- column_FI  output  2  targeted column.
- bit_index_FI  output  4  targeted bit.
- busy  output  1  campaign in progress.
- done  output  1  one-cycle pulse at campaign end.
- golden_out  output  128  golden ciphertext.
- golden_err  output  1  golden run timed out or reported a fault.
- cnt_detected, cnt_undetected, cnt_masked, cnt_timeout  output  CNT_W each  saturating result counters.

Behaviour:
- Reset: all outputs 0, state IDLE.
- States: IDLE, GOLD_LD, GOLD_WAIT, INJ_LD, INJ_WAIT, CLASSIFY, ADVANCE, FIN.
- IDLE + start: clear counters, golden_err and golden_out; latch cfg_*; busy=1; go to GOLD_LD. start while busy is ignored.
- GOLD_LD / INJ_LD:
  - aes_ld=1 for exactly one cycle.
  - aes_key and aes_text_in hold the latched values for the whole campaign.
  - en_FI=0 in GOLD_LD; en_FI=1 in INJ_LD, held through INJ_WAIT.
- WAIT states:
  - Wait counter starts at 0 on entry and increments each cycle.
  - aes_done counts only after aes_done has been sampled low at least once since the ld cycle (arm flag).
  - aes_fault_detected is OR-ed into a sticky flag cleared at each ld.
  - Armed aes_done: capture aes_text_out. GOLD_WAIT then goes to ADVANCE (first point), INJ_WAIT to CLASSIFY.
  - Counter reaching MAX_WAIT without armed done: timeout.
- Golden run: timeout or sticky fault sets golden_err=1 and goes to FIN with no injection runs. Otherwise golden_out=captured text.
- CLASSIFY, one cycle, first match wins, increments exactly one counter:
  - timeout → cnt_timeout
  - sticky fault → cnt_detected
  - captured != golden_out → cnt_undetected
  - else → cnt_masked
  - Counters saturate at all-ones.
- Sweep order (odometer, innermost first): bit_index 0..7 (bit mode only; fixed 0 in byte mode), column 0..3, row 0..3, round 0..NUM_ROUNDS-1, func ascending over set mask bits.
  - Runs per func: bit mode NUM_ROUNDS*128, byte mode NUM_ROUNDS*16.
- ADVANCE: load the next point into the *_FI registers, then INJ_LD. After the last point, go to FIN.
- cfg_func_mask=0: golden run only, then FIN.
- FIN: done=1 for one cycle, busy=0, then IDLE. Counters, golden_out and golden_err hold until the next start.
- mode_FI=cfg_byte_mode while busy; *_FI fields hold their last values when idle.
- rst low mid-campaign: immediate return to reset values, aes_ld dropped. The next start restarts from the golden run.

Optional Feature:
- FI_STOP_ON_UNDETECTED_EN defined:
  - First undetected classification goes to FIN instead of ADVANCE.
  - *_FI outputs freeze at the offending point.
  - Added output stopped (1 bit) is set until the next start.
- Undefined: full sweep always completes; no stopped port.

Decomposition:
- Package fi_pkg:
  - state enum
  - func codes FI_SBOX=0, FI_SHRW=1, FI_MXCL=2, FI_KYXR=3
  - result class codes
  - ROW_MAX/COL_MAX/BIT_MAX constants
- Sub-module fi_sweep_cnt: odometer over func/round/row/column/bit with load, step, byte-mode skip and last-point flag.

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, func_mask=0, start → one ld, golden_out=69c4e0d86a7b0430d8cdb78070b4c55a, done pulse, all counters 0.
- Same vectors, byte mode, func_mask=0001, aes model detecting every fault → cnt_detected=160, other counters 0, 161 ld pulses.
- Bit mode, func_mask=1000, stub returning golden text with no fault → cnt_masked=1280, last point round 9/row 3/col 3/bit 7.
- Stub that never raises done after the golden run, byte mode, func_mask=0001 → cnt_timeout=160, each run exactly MAX_WAIT cycles long. Stub silent on the golden run → golden_err=1, zero injection runs.
- rst low during INJ_WAIT → all outputs 0 without a clock edge; next start replays the golden run.
- With FI_STOP_ON_UNDETECTED_EN: stub corrupts output undetected at round 3 → stopped=1, round_FI=3, cnt_undetected=1, done pulse.
